// File: rtl/sa_cdc_hs_pkg.sv
// Shared types and default constants for the 4-phase req/ack CDC source controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sa_cdc_hs_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2,
    ERR    = 2'd3
  } hs_state_t;

  localparam int SYNC_STAGES_DEF = 3;
  localparam int TIMEOUT_DEF     = 1000;
  localparam int TO_W_DEF        = 12;
  localparam int XFER_CNT_W      = 16;

endpackage

// File: rtl/sa_sync_nff.sv
// N-flop synchronizer bringing a single asynchronous level into the clk domain.
// Latency: STAGES clk edges from d to q.
// Backpressure: none; pure level follower.
//
// Ports: clk, rst (sync, active-high), d (async level in), q (synchronized level out).
module sa_sync_nff #(
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/sa_cdc_hs_ctrl.sv
// Source-side sequencer for a 4-phase req/ack crossing: holds one word on xdata and walks req/ack through a full cycle.
// Latency: zero-delay loopback gives REQ_LO at edge SYNC_STAGES+1 and IDLE at edge 2*(SYNC_STAGES+1) after capture.
// Backpressure: in_ready only in IDLE; a stalled far side parks the FSM in ERR until err_clr with ack low.
//
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data source word; xreq/xdata to destination domain
// (both straight from flops); xack_async from destination; busy, err (sticky), err_clr; xfer_cnt completed transfers.
module sa_cdc_hs_ctrl
  import sa_cdc_hs_pkg::*;
#(
  parameter int DW          = 32,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int TO_W        = TO_W_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DW-1:0]         in_data,
  output logic                  xreq,
  output logic [DW-1:0]         xdata,
  input  logic                  xack_async,
  output logic                  busy,
  output logic                  err,
  input  logic                  err_clr,
  output logic [XFER_CNT_W-1:0] xfer_cnt
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  hs_state_t             state_q, state_d;
  logic                  xreq_q, xreq_d;
  logic                  err_q, err_d;
  logic [DW-1:0]         xdata_q;
  logic [TO_W-1:0]       timer_q, timer_d;
  logic [XFER_CNT_W-1:0] xfer_cnt_q;
  logic                  capture;
  logic                  cnt_inc;
  logic                  timeout_hit;
  logic                  ack_s;

  // The FSM only ever looks at the synchronized ack.
  sa_sync_nff #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (xack_async),
    .q   (ack_s)
  );

  assign in_ready = (state_q == IDLE) && !rst;

  always_comb begin
    state_d     = state_q;
    xreq_d      = xreq_q;
    err_d       = err_q;
    capture     = 1'b0;
    cnt_inc     = 1'b0;
    timeout_hit = (TIMEOUT != 0) && (timer_q == TO_LAST);

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          capture = 1'b1;
          xreq_d  = 1'b1;
          state_d = REQ_HI;
        end
      end
      // In both wait states the exit condition is tested first so it wins
      // over a timeout landing on the same edge.
      REQ_HI: begin
        if (ack_s) begin
          xreq_d  = 1'b0;
          state_d = REQ_LO;
        end else if (timeout_hit) begin
          xreq_d  = 1'b0;
          err_d   = 1'b1;
          state_d = ERR;
        end
      end
      REQ_LO: begin
        if (!ack_s) begin
          cnt_inc = 1'b1;
          state_d = IDLE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = ERR;
        end
      end
      ERR: begin
        xreq_d = 1'b0;
        err_d  = 1'b1;
        // Leaving while ack is still high would let a stale ack start the
        // next handshake half-way through, so err_clr waits for ack low.
        if (err_clr && !ack_s) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        xreq_d  = 1'b0;
        state_d = IDLE;
      end
    endcase

    // Timer restarts on every state change and saturates instead of wrapping.
    if (state_d != state_q) begin
      timer_d = '0;
    end else if ((state_q == REQ_HI || state_q == REQ_LO) && (timer_q != '1)) begin
      timer_d = timer_q + TO_W'(1);
    end else begin
      timer_d = timer_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      xreq_q     <= 1'b0;
      err_q      <= 1'b0;
      xdata_q    <= '0;
      timer_q    <= '0;
      xfer_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      xreq_q  <= xreq_d;
      err_q   <= err_d;
      timer_q <= timer_d;
      if (capture) begin
        xdata_q <= in_data;
      end
      if (cnt_inc) begin
        xfer_cnt_q <= xfer_cnt_q + XFER_CNT_W'(1);
      end
    end
  end

  assign xreq     = xreq_q;
  assign xdata    = xdata_q;
  assign err      = err_q;
  assign busy     = (state_q != IDLE);
  assign xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_sa_cdc_hs_ctrl.sv
// Directed bench for sa_cdc_hs_ctrl: loopback transfers, timeouts in both wait states, err_clr handling, reset abort, counter wrap.
// Latency: checks are taken 1 time unit after each rising edge.
// Backpressure: far-side ack is either looped back from xreq or driven directly by the bench.
module tb_sa_cdc_hs_ctrl;

  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          xreq;
  logic [DW-1:0] xdata;
  logic          xack_async;
  logic          busy;
  logic          err;
  logic          err_clr;
  logic [15:0]   xfer_cnt;

  logic          loop_en;
  logic          ack_drv;

  int n_tests = 0;
  int n_fail  = 0;

  assign xack_async = loop_en ? xreq : ack_drv;

  sa_cdc_hs_ctrl #(
    .DW          (DW),
    .SYNC_STAGES (3),
    .TO_W        (12),
    .TIMEOUT     (1000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .xreq       (xreq),
    .xdata      (xdata),
    .xack_async (xack_async),
    .busy       (busy),
    .err        (err),
    .err_clr    (err_clr),
    .xfer_cnt   (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    err_clr  = 1'b0;
    loop_en  = 1'b0;
    ack_drv  = 1'b0;

    // Reset state
    tick(3);
    chk("rst_in_ready_low", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_xreq", {31'd0, xreq}, 32'd0);
    chk("rst_xdata", xdata, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cnt", {16'd0, xfer_cnt}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Spurious ack in IDLE, and err_clr outside ERR, change nothing
    ack_drv = 1'b1;
    err_clr = 1'b1;
    tick(5);
    chk("spur_busy", {31'd0, busy}, 32'd0);
    chk("spur_xreq", {31'd0, xreq}, 32'd0);
    chk("spur_err", {31'd0, err}, 32'd0);
    ack_drv = 1'b0;
    err_clr = 1'b0;
    tick(4);

    // Loopback, in_valid held high, three words
    loop_en  = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h1111_1111;
    tick(1);                                   // edge 0: capture
    chk("lb0_xdata", xdata, 32'h1111_1111);
    chk("lb0_xreq", {31'd0, xreq}, 32'd1);
    chk("lb0_in_ready", {31'd0, in_ready}, 32'd0);
    in_data = 32'h2222_2222;
    tick(3);                                   // edge 3: ack_s just rose
    chk("lb3_xreq_still_hi", {31'd0, xreq}, 32'd1);
    tick(1);                                   // edge 4: REQ_LO
    chk("lb4_xreq_lo", {31'd0, xreq}, 32'd0);
    chk("lb4_busy", {31'd0, busy}, 32'd1);
    chk("lb4_xdata_held", xdata, 32'h1111_1111);
    tick(3);                                   // edge 7: still waiting for ack low
    chk("lb7_busy", {31'd0, busy}, 32'd1);
    tick(1);                                   // edge 8: back in IDLE
    chk("lb8_busy", {31'd0, busy}, 32'd0);
    chk("lb8_cnt", {16'd0, xfer_cnt}, 32'd1);
    tick(1);                                   // edge 9: second capture
    chk("lb9_xdata", xdata, 32'h2222_2222);
    in_data = 32'h3333_3333;
    tick(9);                                   // edge 18: third capture
    chk("lb18_xdata", xdata, 32'h3333_3333);
    chk("lb18_cnt", {16'd0, xfer_cnt}, 32'd2);
    in_valid = 1'b0;
    tick(8);                                   // edge 26: third transfer done
    chk("lb26_cnt", {16'd0, xfer_cnt}, 32'd3);
    chk("lb26_busy", {31'd0, busy}, 32'd0);
    loop_en = 1'b0;

    // Far side never acks: timeout in REQ_HI
    in_valid = 1'b1;
    in_data  = 32'hA5A5_0004;
    tick(1);                                   // edge 0
    in_valid = 1'b0;
    tick(999);                                 // edge 999
    chk("tohi_pre_err", {31'd0, err}, 32'd0);
    chk("tohi_pre_xreq", {31'd0, xreq}, 32'd1);
    tick(2);                                   // edge 1001
    chk("tohi_err", {31'd0, err}, 32'd1);
    chk("tohi_xreq", {31'd0, xreq}, 32'd0);
    chk("tohi_in_ready", {31'd0, in_ready}, 32'd0);
    chk("tohi_busy", {31'd0, busy}, 32'd1);
    chk("tohi_cnt", {16'd0, xfer_cnt}, 32'd3);
    chk("tohi_xdata", xdata, 32'hA5A5_0004);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("tohi_clr_err", {31'd0, err}, 32'd0);
    chk("tohi_clr_busy", {31'd0, busy}, 32'd0);

    // Ack stuck high: timeout in REQ_LO, err_clr held off until ack drops
    in_valid = 1'b1;
    in_data  = 32'h5A5A_0005;
    tick(1);                                   // edge 0
    in_valid = 1'b0;
    ack_drv  = 1'b1;
    tick(4);                                   // edge 4: REQ_LO
    chk("tolo_xreq", {31'd0, xreq}, 32'd0);
    chk("tolo_busy", {31'd0, busy}, 32'd1);
    tick(999);                                 // edge 1003
    chk("tolo_pre_err", {31'd0, err}, 32'd0);
    tick(2);                                   // edge 1005
    chk("tolo_err", {31'd0, err}, 32'd1);
    err_clr = 1'b1;
    tick(3);
    chk("tolo_clr_held_err", {31'd0, err}, 32'd1);
    chk("tolo_clr_held_busy", {31'd0, busy}, 32'd1);
    ack_drv = 1'b0;                            // drop at D
    tick(3);                                   // D+3
    chk("tolo_drop3_err", {31'd0, err}, 32'd1);
    tick(1);                                   // D+4
    chk("tolo_drop4_err", {31'd0, err}, 32'd0);
    chk("tolo_drop4_busy", {31'd0, busy}, 32'd0);
    chk("tolo_cnt", {16'd0, xfer_cnt}, 32'd3);
    err_clr = 1'b0;

    // Ack lands on the timeout edge: exit wins
    in_valid = 1'b1;
    in_data  = 32'h0000_0006;
    tick(1);                                   // edge 0
    in_valid = 1'b0;
    tick(996);                                 // edge 996
    ack_drv = 1'b1;                            // ack_s high before edge 1000
    tick(4);                                   // edge 1000
    chk("coin_err", {31'd0, err}, 32'd0);
    chk("coin_xreq", {31'd0, xreq}, 32'd0);
    chk("coin_busy", {31'd0, busy}, 32'd1);
    ack_drv = 1'b0;
    tick(4);
    chk("coin_done_busy", {31'd0, busy}, 32'd0);
    chk("coin_done_cnt", {16'd0, xfer_cnt}, 32'd4);

    // Reset pulsed in REQ_LO aborts the handshake
    loop_en  = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    tick(1);                                   // edge 0
    in_valid = 1'b0;
    tick(5);                                   // edge 5: REQ_LO
    chk("rlo_xreq", {31'd0, xreq}, 32'd0);
    chk("rlo_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick(1);
    chk("rlo_rst_busy", {31'd0, busy}, 32'd0);
    chk("rlo_rst_xdata", xdata, 32'd0);
    chk("rlo_rst_cnt", {16'd0, xfer_cnt}, 32'd0);
    chk("rlo_rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rlo_in_ready", {31'd0, in_ready}, 32'd1);
    tick(4);
    chk("rlo_cnt_after", {16'd0, xfer_cnt}, 32'd0);

    // Counter wrap 0xFFFF -> 0x0000
    force dut.xfer_cnt_q = 16'hFFFF;
    #1;
    release dut.xfer_cnt_q;
    #1;
    chk("wrap_pre", {16'd0, xfer_cnt}, 32'h0000_FFFF);
    in_valid = 1'b1;
    in_data  = 32'h0BAD_F00D;
    tick(1);                                   // edge 0
    in_valid = 1'b0;
    tick(8);                                   // edge 8
    chk("wrap_cnt", {16'd0, xfer_cnt}, 32'd0);
    chk("wrap_err", {31'd0, err}, 32'd0);
    chk("wrap_busy", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
